// File: rtl/cordic_feeder.sv
// Issue stage for the cordic pipeline: folds operands into the convergence range,
// buffers them in a small FIFO, issues under credit and tracks results in flight.
module cordic_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  input  logic             issue_en,
  output logic             cord_mode,
  output logic [WIDTH-1:0] cord_x,
  output logic [WIDTH-1:0] cord_y,
  output logic [WIDTH-1:0] cord_z,
  output logic             cord_valid,
  output logic             res_valid,
  output logic             res_fold,
  output logic [15:0]      issued
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 2 + 3 * WIDTH;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
    if (v == $signed(MSB_MASK)) sat_neg = $signed(~MSB_MASK);
    else                        sat_neg = -v;
  endfunction

  logic                    fold_d;
  logic signed [WIDTH-1:0] x_d, y_d;
  logic        [WIDTH-1:0] z_d;
  logic        [EW-1:0]    entry_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;
  logic [EW-1:0]    head;

  logic             cord_mode_q, cord_valid_q, cord_fold_q;
  logic [WIDTH-1:0] cord_x_q, cord_y_q, cord_z_q;
  logic [15:0]      issued_q;
  logic [LATENCY-1:0] vld_dly_q, fold_dly_q;

  // Quadrant fold: rotation folds on |z| >= 90 deg, vectoring on x < 0.
  always_comb begin
    fold_d = in_mode ? in_x[WIDTH-1] : (in_z[WIDTH-1] ^ in_z[WIDTH-2]);
    x_d    = $signed(in_x);
    y_d    = $signed(in_y);
    z_d    = in_z;
    if (fold_d) begin
      x_d = sat_neg($signed(in_x));
      y_d = sat_neg($signed(in_y));
      z_d = in_z ^ MSB_MASK;
    end
    entry_d = {in_mode, fold_d, x_d, y_d, z_d};
  end

  assign in_ready = (count_q != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && issue_en;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cord_mode_q  <= 1'b0;
      cord_fold_q  <= 1'b0;
      cord_valid_q <= 1'b0;
      cord_x_q     <= '0;
      cord_y_q     <= '0;
      cord_z_q     <= '0;
      issued_q     <= '0;
      vld_dly_q    <= '0;
      fold_dly_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      // Issue register: holds the last operand when nothing is popped.
      cord_valid_q <= pop;
      if (pop) begin
        {cord_mode_q, cord_fold_q, cord_x_q, cord_y_q, cord_z_q} <= head;
        issued_q <= issued_q + 16'd1;
      end
      // The cordic pipe never stalls, so the tracking line shifts every cycle.
      vld_dly_q  <= (vld_dly_q << 1)  | LATENCY'(cord_valid_q);
      fold_dly_q <= (fold_dly_q << 1) | LATENCY'(cord_valid_q & cord_fold_q);
    end
  end

  assign cord_mode  = cord_mode_q;
  assign cord_x     = cord_x_q;
  assign cord_y     = cord_y_q;
  assign cord_z     = cord_z_q;
  assign cord_valid = cord_valid_q;
  assign res_valid  = vld_dly_q[LATENCY-1];
  assign res_fold   = fold_dly_q[LATENCY-1];
  assign issued     = issued_q;

endmodule

// File: tb/tb_cordic_feeder.sv
// Directed bench for cordic_feeder: folding, latency, backpressure, streaming, reset.
module tb_cordic_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_mode;
  logic [15:0] in_x, in_y, in_z;
  logic        issue_en;
  logic        cord_mode, cord_valid, res_valid, res_fold;
  logic [15:0] cord_x, cord_y, cord_z;
  logic [15:0] issued;

  int n_vec = 0;
  int n_err = 0;

  cordic_feeder #(.WIDTH(16), .DEPTH(4), .LATENCY(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .issue_en(issue_en),
    .cord_mode(cord_mode), .cord_x(cord_x), .cord_y(cord_y), .cord_z(cord_z),
    .cord_valid(cord_valid), .res_valid(res_valid), .res_fold(res_fold),
    .issued(issued)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input int lim, output int n, output logic f);
    n = 0;
    while (!res_valid && n < lim) begin
      tick();
      n++;
    end
    f = res_fold;
  endtask

  task automatic single(input string nm, input logic m, input logic [15:0] x, y, z,
                        input logic [15:0] ex, ey, ez, input logic ef, input logic [15:0] eiss);
    int   n;
    logic f;
    in_valid = 1'b1; in_mode = m; in_x = x; in_y = y; in_z = z; issue_en = 1'b1;
    check_vec({nm, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_vec({nm, "_cv0"}, 32'(cord_valid), 32'd0);
    tick();
    check_vec({nm, "_cv1"}, 32'(cord_valid), 32'd1);
    check_vec({nm, "_mode"}, 32'(cord_mode), 32'(m));
    check_vec({nm, "_x"}, 32'(cord_x), 32'(ex));
    check_vec({nm, "_y"}, 32'(cord_y), 32'(ey));
    check_vec({nm, "_z"}, 32'(cord_z), 32'(ez));
    check_vec({nm, "_iss"}, 32'(issued), 32'(eiss));
    wait_res(20, n, f);
    check_vec({nm, "_lat"}, 32'(n + 1), 32'd9);
    check_vec({nm, "_fold"}, 32'(f), 32'(ef));
    tick();
    check_vec({nm, "_rvoff"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic   rdy;
    int     idx, sent, got, bubbles, fold_err, rdy_low, cyc, cv_cnt, rv_cnt;
    logic   expq[$];
    logic   ef;

    reset = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_x = '0; in_y = '0; in_z = '0; issue_en = 1'b0;
    tick(); tick(); tick();
    check_vec("rst_rdy", 32'(in_ready), 32'd1);
    check_vec("rst_cv", 32'(cord_valid), 32'd0);
    check_vec("rst_rv", 32'(res_valid), 32'd0);
    check_vec("rst_iss", 32'(issued), 32'd0);
    check_vec("rst_x", 32'(cord_x), 32'd0);
    reset = 1'b1;
    tick();

    single("rot0", 1'b0, 16'h26DD, 16'h0000, 16'h2000, 16'h26DD, 16'h0000, 16'h2000, 1'b0, 16'd1);
    single("rot135", 1'b0, 16'h1000, 16'h0200, 16'h6000, 16'hF000, 16'hFE00, 16'hE000, 1'b1, 16'd2);
    single("vecsat", 1'b1, 16'h8000, 16'h0100, 16'h0000, 16'h7FFF, 16'hFF00, 16'h8000, 1'b1, 16'd3);

    // Backpressure: six requests against a stalled issue.
    issue_en = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_y = '0; in_z = '0;
    idx = 0; in_x = 16'h0100;
    repeat (6) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        idx++;
        in_x = 16'((idx + 1) * 256);
      end
    end
    check_vec("bp_acc", 32'(idx), 32'd4);
    check_vec("bp_full", 32'(in_ready), 32'd0);
    issue_en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      rdy = in_ready && in_valid;
      tick();
      if (rdy) begin
        idx++;
        if (idx == 6) in_valid = 1'b0;
        else          in_x = 16'((idx + 1) * 256);
      end
      check_vec($sformatf("bp_cv%0d", j), 32'(cord_valid), 32'd1);
      check_vec($sformatf("bp_x%0d", j), 32'(cord_x), 32'((j + 1) * 256));
      if (j == 0) check_vec("bp_rdyback", 32'(in_ready), 32'd1);
    end
    tick();
    check_vec("bp_idle", 32'(cord_valid), 32'd0);
    check_vec("bp_iss", 32'(issued), 32'd9);
    repeat (12) tick();

    // Sustained stream of 300, every third one folded.
    sent = 0; got = 0; bubbles = 0; fold_err = 0; rdy_low = 0; cyc = 0;
    in_valid = 1'b1; in_mode = 1'b0; in_x = 16'h0400; in_y = 16'h0010; in_z = 16'h6000;
    while (got < 300 && cyc < 2000) begin
      rdy = in_valid && in_ready;
      if (in_valid && !in_ready) rdy_low++;
      tick();
      cyc++;
      if (rdy) begin
        expq.push_back(in_z == 16'h6000);
        sent++;
        if (sent == 300) in_valid = 1'b0;
        else             in_z = (sent % 3 == 0) ? 16'h6000 : 16'h1000;
      end
      if (res_valid) begin
        got++;
        ef = (expq.size() > 0) ? expq.pop_front() : 1'bx;
        if (res_fold !== ef) fold_err++;
      end else if (got > 0) begin
        bubbles++;
      end
    end
    check_vec("strm_sent", 32'(sent), 32'd300);
    check_vec("strm_res", 32'(got), 32'd300);
    check_vec("strm_bub", 32'(bubbles), 32'd0);
    check_vec("strm_fold", 32'(fold_err), 32'd0);
    check_vec("strm_rdylow", 32'(rdy_low), 32'd0);
    check_vec("strm_iss", 32'(issued), 32'd309);
    repeat (4) tick();

    // Reset with 5 in flight and 3 queued.
    in_valid = 1'b1; issue_en = 1'b1; in_z = 16'h1000;
    repeat (5) tick();
    in_valid = 1'b0;
    tick();
    issue_en = 1'b0; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check_vec("mr_iss", 32'(issued), 32'd314);
    #1 reset = 1'b0;
    #1;
    check_vec("mr_rdy", 32'(in_ready), 32'd1);
    check_vec("mr_cv", 32'(cord_valid), 32'd0);
    check_vec("mr_rv", 32'(res_valid), 32'd0);
    check_vec("mr_rf", 32'(res_fold), 32'd0);
    check_vec("mr_iss0", 32'(issued), 32'd0);
    check_vec("mr_z", 32'(cord_z), 32'd0);
    reset = 1'b1; issue_en = 1'b1;
    cv_cnt = 0; rv_cnt = 0;
    repeat (20) begin
      tick();
      if (cord_valid) cv_cnt++;
      if (res_valid)  rv_cnt++;
    end
    check_vec("mr_nocv", 32'(cv_cnt), 32'd0);
    check_vec("mr_norv", 32'(rv_cnt), 32'd0);
    check_vec("mr_iss_end", 32'(issued), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
